pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter owner and instruction-fetch sequencer; consumer end of the PCS/PCSrc path.
//  Holds PC and fetches from instruction memory over a req/ack handshake.
//  Presents each fetched word to decode with a valid flag.
//  On consumption, advances PC to PC+4, or to a branch/Rd=R15 target when pcsrc_i=1.
// PARAMETERS
//  AW         32            address/data width
//  RESET_PC   32'h00000000  PC loaded on reset
//  FAULT_VEC  32'h0000000C  PC loaded on misaligned target (PC_ALIGN_CHECK_EN only)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  pcsrc_i      in   1   redirect request: PCS gated by condition check
//  target_i     in   AW  redirect target (ALU result / Result bus)
//  stall_i      in   1   1 = decode not accepting current instruction
//  imem_req_o   out  1   fetch request, registered
//  imem_addr_o  out  AW  fetch address, registered
//  imem_ack_i   in   1   memory response valid; sampled only while imem_req_o=1
//  imem_rdata_i in   AW  instruction word, valid with imem_ack_i
//  instr_o      out  AW  held instruction
//  instr_vld_o  out  1   instr_o valid
//  pc_o         out  AW  address of instr_o
//  pc_plus8_o   out  AW  pc_o+8, combinational (ARM R15 read value)
//  align_fault_o out 1   1-cycle pulse; misaligned redirect (tied 0 if macro absent)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc_o=RESET_PC, imem_addr_o=RESET_PC, imem_req_o=0,
//   instr_o=0, instr_vld_o=0, align_fault_o=0.
//  FSM: IDLE -> REQ -> ISSUED -> REQ ...
//   IDLE  : one cycle after reset release; next edge imem_req_o<=1, imem_addr_o<=pc_o, go REQ.
//   REQ   : imem_req_o=1, imem_addr_o stable until ack.
//           On imem_ack_i=1: instr_o<=imem_rdata_i, instr_vld_o<=1, imem_req_o<=0, go ISSUED.
//           Zero-wait ack (first REQ cycle) allowed; min 2 cycles per instruction.
//   ISSUED: stall_i=1 -> hold instr_o, instr_vld_o, pc_o unchanged.
//           stall_i=0 -> instruction consumed this edge: instr_vld_o<=0;
//           next = pcsrc_i ? {target_i[AW-1:2],2'b00} : pc_o+4;
//           pc_o<=next, imem_addr_o<=next, imem_req_o<=1, go REQ.
//  pcsrc_i/target_i sampled only in ISSUED with stall_i=0; ignored in all other states.
//  Arithmetic: PC+4 wraps modulo 2^AW (0xFFFFFFFC -> 0x00000000); pc_plus8 wraps likewise.
//  imem_ack_i while imem_req_o=0: ignored, no state change.
//  Reset mid-fetch: outstanding request abandoned; late ack after release ignored in IDLE.
//  stall_i in REQ: no effect; fetch completes, word held in ISSUED.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//   redirect with target_i[1:0]!=0: pc_o<=FAULT_VEC, fetch from FAULT_VEC;
//   align_fault_o=1 exactly one cycle after the consume edge.
//  PC_ALIGN_CHECK_EN undefined: target_i[1:0] forced to 00, align_fault_o constant 0.
// TESTING
//  1 reset=1 mid-run -> pc_o=0, imem_req_o=0, instr_vld_o=0 immediately;
//    release -> 2nd edge imem_req_o=1, imem_addr_o=0.
//  2 zero-wait ack, rdata E3A00001/E2800001, stall=0, pcsrc=0 -> addrs 0,4,8;
//    instr_o matches each word; pc_plus8_o=pc_o+8.
//  3 consume at pc=0x8 with pcsrc_i=1, target_i=0x100 -> imem_addr_o=0x100,
//    then pc_o=0x100, pc_plus8_o=0x108.
//  4 ack delayed 3 cycles -> imem_addr_o stable throughout;
//    stall_i=1 for 2 cycles -> instr_o/pc_o held, no new req.
//  5 RESET_PC=0xFFFFFFFC -> second fetch imem_addr_o=0x00000000.
//  6 redirect target 0x102 -> macro off: addr 0x100, align_fault_o=0;
//    macro on: addr=FAULT_VEC, align_fault_o 1-cycle pulse.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner and instruction-fetch sequencer (IDLE -> REQ -> ISSUED -> REQ ...).
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirects go to FAULT_VEC and pulse align_fault_o.
module pc_fetch_ctrl #(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [AW-1:0] FAULT_VEC = AW'(32'h0000_000C)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pcsrc_i,
    input  logic [AW-1:0] target_i,
    input  logic          stall_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic          imem_ack_i,
    input  logic [AW-1:0] imem_rdata_i,
    output logic [AW-1:0] instr_o,
    output logic          instr_vld_o,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] pc_plus8_o,
    output logic          align_fault_o,
    output logic [1:0]    dbg_state_o
);

    // Handshake: a fetch is outstanding while imem_req_o=1 and completes on the first
    // edge with imem_ack_i=1; the instruction is consumed on the first ISSUED edge with stall_i=0.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ISSUED = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_addr;
    logic          r_req;
    logic [AW-1:0] r_instr;
    logic          r_vld;
    logic          r_idle_done;

    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic          w_req_nxt;
    logic [AW-1:0] w_instr_nxt;
    logic          w_vld_nxt;
    logic          w_idle_done_nxt;
    logic [AW-1:0] w_next_pc;
    logic [AW-1:0] w_seq_pc;
    logic [AW-1:0] w_redirect_pc;
    logic          w_misaligned;

    assign w_seq_pc      = r_pc + AW'(4);
    assign w_redirect_pc = {target_i[AW-1:2], 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    logic r_fault;

    assign w_misaligned = pcsrc_i && (target_i[1:0] != 2'b00);
    assign w_next_pc    = w_misaligned ? FAULT_VEC :
                          (pcsrc_i ? w_redirect_pc : w_seq_pc);

    // Pulse lands the cycle after the consume edge that took the faulting redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (r_state == ST_ISSUED) && !stall_i && w_misaligned;
        end
    end

    assign align_fault_o = r_fault;
`else
    logic w_unused_tgt_lsb;

    assign w_unused_tgt_lsb = ^target_i[1:0];
    assign w_misaligned     = 1'b0;
    assign w_next_pc        = pcsrc_i ? w_redirect_pc : w_seq_pc;
    assign align_fault_o    = w_misaligned;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_req       <= 1'b0;
            r_instr     <= '0;
            r_vld       <= 1'b0;
            r_idle_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_addr      <= w_addr_nxt;
            r_req       <= w_req_nxt;
            r_instr     <= w_instr_nxt;
            r_vld       <= w_vld_nxt;
            r_idle_done <= w_idle_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_addr_nxt      = r_addr;
        w_req_nxt       = r_req;
        w_instr_nxt     = r_instr;
        w_vld_nxt       = r_vld;
        w_idle_done_nxt = r_idle_done;

        case (r_state)
            // First edge after release only arms; the request goes out on the second.
            ST_IDLE: begin
                if (!r_idle_done) begin
                    w_idle_done_nxt = 1'b1;
                end else begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (r_req && imem_ack_i) begin
                    w_instr_nxt = imem_rdata_i;
                    w_vld_nxt   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_ISSUED;
                end
            end
            ST_ISSUED: begin
                if (!stall_i) begin
                    w_vld_nxt   = 1'b0;
                    w_pc_nxt    = w_next_pc;
                    w_addr_nxt  = w_next_pc;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;
    assign instr_o     = r_instr;
    assign instr_vld_o = r_vld;
    assign pc_o        = r_pc;
    assign pc_plus8_o  = r_pc + AW'(8);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, sequential fetch, redirect, wait states, stall, wrap, alignment.
module tb_pc_fetch_ctrl;

    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          pcsrc_i;
    logic [AW-1:0] target_i;
    logic          stall_i;
    logic          imem_ack_i;
    logic [AW-1:0] imem_rdata_i;

    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic [AW-1:0] instr_o;
    logic          instr_vld_o;
    logic [AW-1:0] pc_o;
    logic [AW-1:0] pc_plus8_o;
    logic          align_fault_o;
    logic [1:0]    dbg_state_o;

    logic          w_req2;
    logic [AW-1:0] w_addr2;
    logic [AW-1:0] w_rdata2;
    logic [AW-1:0] w_instr2;
    logic          w_vld2;
    logic [AW-1:0] w_pc2;
    logic [AW-1:0] w_pc8_2;
    logic          w_fault2;
    logic [1:0]    w_state2;

    int n_checks;
    int n_errors;

    // Instruction memory contents: two fixed words, everything else address-tagged.
    function automatic logic [AW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'hE3A0_0001;
            32'h0000_0004: mem_word = 32'hE280_0001;
            default:       mem_word = 32'hE1A0_0000 ^ a;
        endcase
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);
    assign w_rdata2     = 32'hAAAA_0000 ^ w_addr2;

    pc_fetch_ctrl #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .pcsrc_i(pcsrc_i), .target_i(target_i), .stall_i(stall_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(imem_rdata_i), .instr_o(instr_o), .instr_vld_o(instr_vld_o),
        .pc_o(pc_o), .pc_plus8_o(pc_plus8_o), .align_fault_o(align_fault_o),
        .dbg_state_o(dbg_state_o)
    );

    pc_fetch_ctrl #(.AW(AW), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .pcsrc_i(1'b0), .target_i(target_i), .stall_i(1'b0),
        .imem_req_o(w_req2), .imem_addr_o(w_addr2), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(w_rdata2), .instr_o(w_instr2), .instr_vld_o(w_vld2),
        .pc_o(w_pc2), .pc_plus8_o(w_pc8_2), .align_fault_o(w_fault2),
        .dbg_state_o(w_state2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        pcsrc_i      = 1'b0;
        target_i     = '0;
        stall_i      = 1'b0;
        imem_ack_i   = 1'b0;
        cyc(); cyc();

        check("rst_pc", pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_req", 32'(imem_req_o), 32'h0);
        check("rst_vld", 32'(instr_vld_o), 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_fault", 32'(align_fault_o), 32'h0);
        check("rst_state", 32'(dbg_state_o), 32'h0);
        check("rst_pc_wrap", w_pc2, 32'hFFFF_FFFC);

        // Release; ack held high so fetches are zero-wait and IDLE must ignore it.
        reset      = 1'b0;
        imem_ack_i = 1'b1;
        cyc();
        check("idle_req_e1", 32'(imem_req_o), 32'h0);
        check("idle_state_e1", 32'(dbg_state_o), 32'h0);
        cyc();
        check("req_e2", 32'(imem_req_o), 32'h1);
        check("addr_e2", imem_addr_o, 32'h0);
        check("wrap_addr_first", w_addr2, 32'hFFFF_FFFC);

        // Sequential zero-wait fetches at 0, 4, 8
        cyc();
        check("i0_instr", instr_o, 32'hE3A0_0001);
        check("i0_vld", 32'(instr_vld_o), 32'h1);
        check("i0_req_low", 32'(imem_req_o), 32'h0);
        check("i0_pc", pc_o, 32'h0);
        check("i0_pc8", pc_plus8_o, 32'h8);
        cyc();
        check("i1_addr", imem_addr_o, 32'h4);
        check("i1_vld_low", 32'(instr_vld_o), 32'h0);
        check("wrap_addr_second", w_addr2, 32'h0);
        check("wrap_pc8", w_pc8_2, 32'h8);
        cyc();
        check("i1_instr", instr_o, 32'hE280_0001);
        check("i1_pc8", pc_plus8_o, 32'hC);
        cyc();
        check("i2_addr", imem_addr_o, 32'h8);
        cyc();
        check("i2_instr", instr_o, 32'hE1A0_0008);
        check("i2_pc", pc_o, 32'h8);

        // Redirect on consume at pc=8
        pcsrc_i  = 1'b1;
        target_i = 32'h100;
        cyc();
        check("br_addr", imem_addr_o, 32'h100);
        check("br_pc", pc_o, 32'h100);
        check("br_pc8", pc_plus8_o, 32'h108);

        // Three-cycle ack delay; pcsrc left high in REQ must be ignored
        imem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("wait_req", 32'(imem_req_o), 32'h1);
            check("wait_addr", imem_addr_o, 32'h100);
            check("wait_state", 32'(dbg_state_o), 32'h1);
        end
        pcsrc_i    = 1'b0;
        imem_ack_i = 1'b1;
        stall_i    = 1'b1;
        cyc();
        check("late_instr", instr_o, 32'hE1A0_0100);
        check("late_vld", 32'(instr_vld_o), 32'h1);

        // Stall two more cycles: all held, no request (ack stays high and is ignored)
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("stall_instr", instr_o, 32'hE1A0_0100);
            check("stall_vld", 32'(instr_vld_o), 32'h1);
            check("stall_pc", pc_o, 32'h100);
            check("stall_req", 32'(imem_req_o), 32'h0);
        end
        stall_i = 1'b0;
        cyc();
        check("unstall_addr", imem_addr_o, 32'h104);
        check("unstall_req", 32'(imem_req_o), 32'h1);

        // stall_i in REQ has no effect: fetch still completes
        stall_i = 1'b1;
        cyc();
        check("reqstall_vld", 32'(instr_vld_o), 32'h1);
        check("reqstall_instr", instr_o, 32'hE1A0_0104);

        // Misaligned redirect to 0x102
        stall_i  = 1'b0;
        pcsrc_i  = 1'b1;
        target_i = 32'h102;
        cyc();
        pcsrc_i  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check("mis_addr", imem_addr_o, 32'hC);
        check("mis_pc", pc_o, 32'hC);
        check("mis_fault", 32'(align_fault_o), 32'h1);
`else
        check("mis_addr", imem_addr_o, 32'h100);
        check("mis_pc", pc_o, 32'h100);
        check("mis_fault", 32'(align_fault_o), 32'h0);
`endif
        cyc();
        check("mis_fault_end", 32'(align_fault_o), 32'h0);
        check("mis_fetch_vld", 32'(instr_vld_o), 32'h1);

        // Reset mid-fetch: consume now, then assert reset between edges while in REQ
        stall_i    = 1'b0;
        imem_ack_i = 1'b0;
        cyc();
        check("pre_rst_req", 32'(imem_req_o), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_pc", pc_o, 32'h0);
        check("mid_rst_req", 32'(imem_req_o), 32'h0);
        check("mid_rst_vld", 32'(instr_vld_o), 32'h0);
        imem_ack_i = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        check("rel_req_e1", 32'(imem_req_o), 32'h0);
        check("rel_vld_e1", 32'(instr_vld_o), 32'h0);
        cyc();
        check("rel_req_e2", 32'(imem_req_o), 32'h1);
        check("rel_addr_e2", imem_addr_o, 32'h0);
        cyc();
        check("rel_instr", instr_o, 32'hE3A0_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
